spike_rate_decoder: RTL and testbench
=====================================

// Module: spike_rate_decoder
// PURPOSE
//   Receive end of the neuron PWM spike output: recovers the membrane value encoded as
//   a duty cycle on each is_spike line by counting high cycles over a window of
//   2**WIDTH clocks. Decodes CHANNELS neurons in parallel, presents all values together
//   with a one-cycle valid strobe. Sits between a neuron layer and readout/next-layer logic.
// PARAMETERS
//   CHANNELS      8   number of spike lines decoded in parallel
//   WIDTH         6   decoded value width; window = 2**WIDTH cycles (= PWM width of a 32-synapse neuron)
//   REQUIRE_SYNC  1   1: stay IDLE until first sync pulse; 0: start counting on first enabled cycle
// PORTS
//   clk       in   1               clock, all state updates on posedge
//   reset     in   1               asynchronous, active-high; clears all state
//   enable    in   1               advance window/accumulate this cycle; low = freeze
//   sync      in   1               restart window (align to transmitter PWM period)
//   spikes    in   CHANNELS        PWM spike lines, bit i = channel i
//   values    out  CHANNELS*WIDTH  decoded values, channel i at [i*WIDTH +: WIDTH]
//   valid     out  1               one-cycle pulse: values updated this cycle
//   saturated out  CHANNELS        per-channel: line was high all 2**WIDTH cycles of last window
// BEHAVIOUR
//   - Reset (async): state=IDLE (RUN if REQUIRE_SYNC=0), phase=0, accumulators=0,
//     values=0, valid=0, saturated=0. Reset mid-window discards the partial window.
//   - FSM IDLE: phase/accs held at 0; spikes ignored. IDLE->RUN on sync=1 (that cycle is
//     phase 0 and its spikes ARE counted). REQUIRE_SYNC=0: reset leaves FSM in RUN.
//   - FSM RUN, enable=1: acc[i] <= acc[i] + spikes[i], saturating at 2**WIDTH-1;
//     phase <= phase+1 (wraps at 2**WIDTH).
//   - Window end: enabled cycle with phase==2**WIDTH-1. Next edge: values[i] <= saturating
//     acc[i]+spikes[i]; saturated[i] <= (acc[i]==2**WIDTH-1 && spikes[i]); valid <= 1;
//     accs <= 0; phase <= 0. Latency: values visible the cycle after last window cycle.
//   - valid is high exactly one cycle per completed window, 0 otherwise; values and
//     saturated hold until the next window end or reset.
//   - enable=0: phase, accs, FSM frozen; spikes ignored; valid forced 0 next cycle.
//   - sync=1 in RUN (with enable): phase <= 1, acc[i] <= spikes[i] (cycle counted as
//     phase 0); partial window discarded, no valid. sync wins over simultaneous window end
//     (no valid, values unchanged). sync with enable=0 is ignored.
//   - Round-trip: PWM transmitter with value v (0..2**WIDTH-1), sync aligned to its
//     counter wrap, decodes to exactly v.
// STRUCTURE
//   - Shared package: localparam WINDOW = 2**WIDTH; FSM state enum {IDLE, RUN}.
//   - Sub-module spike_counter (one instance per channel): saturating WIDTH-bit counter
//     with inc, clear, load-first inputs and sat output. Phase counter + FSM + output
//     registers in top level.
// TESTING
//   1. CHANNELS=8, WIDTH=6; reset, sync, drive ch0 from pwm of value 5 for 64 cycles
//      -> valid pulses once, values[5:0]=5, saturated[0]=0.
//   2. ch1 tied high, ch2 tied low for full window -> values ch1=63, saturated[1]=1;
//      ch2=0, saturated[2]=0.
//   3. enable low for 10 cycles mid-window, ch0 value 20 -> valid delayed 10 cycles,
//      still decodes 20; no valid during stall.
//   4. sync asserted at phase 30 with ch0 high -> no valid at old window end; next valid
//      64 cycles after sync; partial counts gone.
//   5. sync on same cycle as phase 63 -> valid stays 0, previous values unchanged.
//   6. Assert reset at phase 40 -> values=0, valid=0 immediately (async); REQUIRE_SYNC=1:
//      spikes ignored until next sync.

Source files
------------

// File: rtl/spike_rate_decoder_pkg.sv
// Shared definitions for the PWM spike-rate decoder.
// Window length helper and decoder FSM state type.
package spike_rate_decoder_pkg;

   localparam int DEF_CHANNELS = 8;
   localparam int DEF_WIDTH    = 6;

   function automatic int window_of(input int width);
      return 1 << width;
   endfunction

   localparam int WINDOW = window_of(DEF_WIDTH);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/spike_rate_decoder_counter.sv
// Per-channel saturating high-cycle counter.
// Exposes the would-be next count so the window end can capture it.
module spike_counter
   import spike_rate_decoder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc_i,
   input  logic             adv_i,
   input  logic             clear_i,
   input  logic             load_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             sat_o
);

   localparam logic [WIDTH-1:0] MAX = '1;

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;
   logic             full;

   assign full  = (cnt_q == MAX);
   assign sum_o = full ? MAX : cnt_q + WIDTH'(inc_i);
   assign sat_o = full & inc_i;

   // load restarts a window with this cycle's spike; clear ends one
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = WIDTH'(inc_i);
      end else if (clear_i) begin
         cnt_d = '0;
      end else if (adv_i) begin
         cnt_d = sum_o;
      end
   end

   // counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spike_rate_decoder.sv
// Decodes CHANNELS PWM spike lines into duty-cycle values
// over a 2**WIDTH cycle window, with a one-cycle valid strobe.
module spike_rate_decoder
   import spike_rate_decoder_pkg::*;
#(
   parameter int CHANNELS     = DEF_CHANNELS,
   parameter int WIDTH        = DEF_WIDTH,
   parameter int REQUIRE_SYNC = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      sync,
   input  logic [CHANNELS-1:0]       spikes,
   output logic [CHANNELS*WIDTH-1:0] values,
   output logic                      valid,
   output logic [CHANNELS-1:0]       saturated
);

   localparam logic [WIDTH-1:0] PMAX =
      WIDTH'(window_of(WIDTH) - 1);
   localparam state_e RST_STATE =
      (REQUIRE_SYNC != 0) ? ST_IDLE : ST_RUN;

   state_e                      state_q;
   state_e                      state_d;
   logic [WIDTH-1:0]            phase_q;
   logic [WIDTH-1:0]            phase_d;
   logic [CHANNELS*WIDTH-1:0]   values_q;
   logic [CHANNELS*WIDTH-1:0]   values_d;
   logic [CHANNELS-1:0]         sat_q;
   logic [CHANNELS-1:0]         sat_d;
   logic                        valid_q;
   logic                        valid_d;

   logic [CHANNELS-1:0][WIDTH-1:0] sums;
   logic [CHANNELS-1:0]            sat_vec;

   logic run_adv;
   logic start;
   logic last;
   logic idle;

   assign idle    = (state_q == ST_IDLE);
   assign run_adv = enable & (state_q == ST_RUN);
   // sync only acts on enabled cycles; it wins over window end
   assign start   = enable & sync;
   assign last    = run_adv & ~sync & (phase_q == PMAX);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      spike_counter #(
         .WIDTH (WIDTH)
      ) u_cnt (
         .clk     (clk),
         .reset   (reset),
         .inc_i   (spikes[i]),
         .adv_i   (run_adv),
         .clear_i (last | idle),
         .load_i  (start),
         .sum_o   (sums[i]),
         .sat_o   (sat_vec[i])
      );
   end

   // phase, FSM and output capture
   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      values_d = values_q;
      sat_d    = sat_q;
      valid_d  = 1'b0;
      if (start) begin
         state_d = ST_RUN;
         phase_d = WIDTH'(1);
      end else if (last) begin
         phase_d  = '0;
         values_d = sums;
         sat_d    = sat_vec;
         valid_d  = 1'b1;
      end else if (run_adv) begin
         phase_d = phase_q + WIDTH'(1);
      end
   end

   // state registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= RST_STATE;
         phase_q  <= '0;
         values_q <= '0;
         sat_q    <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         values_q <= values_d;
         sat_q    <= sat_d;
         valid_q  <= valid_d;
      end
   end

   assign values    = values_q;
   assign valid     = valid_q;
   assign saturated = sat_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench for spike_rate_decoder: PWM windows,
// stalls, resync, sync at window end and mid-window reset.
module tb_spike_rate_decoder;

   localparam int CH  = 8;
   localparam int W   = 6;
   localparam int WIN = 64;

   logic              clk = 1'b0;
   logic              reset;
   logic              enable;
   logic              sync;
   logic [CH-1:0]     spikes;
   logic [CH*W-1:0]   values;
   logic              valid;
   logic [CH-1:0]     saturated;

   always #5 clk = ~clk;

   spike_rate_decoder #(
      .CHANNELS     (CH),
      .WIDTH        (W),
      .REQUIRE_SYNC (1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .sync      (sync),
      .spikes    (spikes),
      .values    (values),
      .valid     (valid),
      .saturated (saturated)
   );

   typedef int vec_t [CH];
   typedef struct {
      logic [CH*W-1:0] val;
      logic [CH-1:0]   sat;
      longint          due;
   } exp_t;

   exp_t   sb[$];
   int     n_checks = 0;
   int     n_fail   = 0;
   longint cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name,
                        input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   function automatic logic [CH*W-1:0] pack_vals(input vec_t v);
      logic [CH*W-1:0] r;
      r = '0;
      for (int i = 0; i < CH; i++)
         r[i*W +: W] = (v[i] >= WIN) ? W'(WIN - 1) : W'(v[i]);
      return r;
   endfunction

   function automatic logic [CH-1:0] pack_sat(input vec_t v);
      logic [CH-1:0] r;
      r = '0;
      for (int i = 0; i < CH; i++) r[i] = (v[i] >= WIN);
      return r;
   endfunction

   // drives PWM cycles cs..ce-1; v[i] high cycles per window
   task automatic win(input vec_t v, input bit first_sync,
                      input int cs, input int ce,
                      input int stall_at, input int stall_len,
                      input bit push);
      exp_t e;
      if (push) begin
         e.val = pack_vals(v);
         e.sat = pack_sat(v);
         e.due = cyc + (ce - cs) + stall_len;
         sb.push_back(e);
      end
      for (int c = cs; c < ce; c++) begin
         if (c == stall_at) begin
            for (int s = 0; s < stall_len; s++) begin
               enable = 1'b0;
               sync   = (s == 2);
               spikes = '1;
               @(negedge clk);
            end
         end
         enable = 1'b1;
         sync   = first_sync && (c == cs);
         for (int i = 0; i < CH; i++) spikes[i] = (c < v[i]);
         @(negedge clk);
      end
      sync   = 1'b0;
      spikes = '0;
   endtask

   // monitor: pops an expectation on every valid strobe
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (valid === 1'b1) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_valid at cycle %0d", cyc);
            end else begin
               e = sb.pop_front();
               check("valid_cycle", 64'(cyc), 64'(e.due));
               check("values", 64'(values), 64'(e.val));
               check("saturated", 64'(saturated), 64'(e.sat));
            end
         end
      end
   end

   initial begin
      vec_t v1, v2, v3, vhi, v4, v5, v6, v7;
      v1  = '{5, 0, 0, 0, 0, 0, 0, 0};
      v2  = '{0, 64, 0, 33, 1, 0, 0, 63};
      v3  = '{20, 0, 0, 0, 0, 64, 0, 0};
      vhi = '{64, 0, 0, 0, 0, 0, 0, 0};
      v4  = '{10, 0, 0, 0, 0, 0, 3, 0};
      v5  = '{7, 0, 0, 2, 0, 0, 0, 0};
      v6  = '{64, 64, 64, 64, 64, 64, 64, 64};
      v7  = '{12, 0, 40, 0, 0, 0, 0, 64};

      reset  = 1'b1;
      enable = 1'b0;
      sync   = 1'b0;
      spikes = '0;
      repeat (3) @(negedge clk);
      check("rst_values", 64'(values), 64'd0);
      check("rst_valid", 64'(valid), 64'd0);
      check("rst_saturated", 64'(saturated), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // basic window, then saturation / boundary mix
      win(v1, 1'b1, 0, WIN, -1, 0, 1'b1);
      win(v2, 1'b0, 0, WIN, -1, 0, 1'b1);

      // 10-cycle stall mid-window
      win(v3, 1'b0, 0, WIN, 30, 10, 1'b1);

      // resync at phase 30 discards partial window
      win(vhi, 1'b0, 0, 30, -1, 0, 1'b0);
      win(v4, 1'b1, 0, WIN, -1, 0, 1'b1);

      // sync lands on phase 63: no valid, values held
      win(vhi, 1'b0, 0, WIN - 1, -1, 0, 1'b0);
      win(v5, 1'b1, 0, 1, -1, 0, 1'b0);
      check("sync_end_valid", 64'(valid), 64'd0);
      check("sync_end_values", 64'(values), 64'(pack_vals(v4)));
      win(v5, 1'b0, 1, WIN, -1, 0, 1'b1);

      // async reset at phase 40
      win(v6, 1'b0, 0, 40, -1, 0, 1'b0);
      reset = 1'b1;
      #1;
      check("async_values", 64'(values), 64'd0);
      check("async_valid", 64'(valid), 64'd0);
      check("async_saturated", 64'(saturated), 64'd0);
      @(negedge clk);
      reset  = 1'b0;
      enable = 1'b1;
      spikes = '1;
      repeat (70) @(negedge clk);
      check("idle_valid", 64'(valid), 64'd0);
      check("idle_values", 64'(values), 64'd0);
      win(v7, 1'b1, 0, WIN, -1, 0, 1'b1);

      enable = 1'b0;
      repeat (5) @(negedge clk);
      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
